// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle main control unit: opcode values,
// FSM state encoding, ALU operand/operation selects and the packed control vector
// driven onto the datapath.
package ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    localparam logic [1:0] ALUB_REG = 2'b00;
    localparam logic [1:0] ALUB_ONE = 2'b01;
    localparam logic [1:0] ALUB_IMM = 2'b10;

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StMemAdr,
        StMemRd,
        StMemWb,
        StMemWr,
        StExec,
        StAluWb,
        StAddiEx,
        StAddiWb,
        StBranch,
        StJump
    } state_e;

    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       iord;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       pc_write;
        logic       branch;
        logic       jump;
        logic       illegal_op;
    } ctrl_t;

    function automatic logic is_legal_op(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/ctrl_out_decode.sv
// Combinational decode of the control FSM state into the datapath control vector.
// Ports:
//   state     in   current FSM state
//   opcode    in   IR[31:26], only looked at in DECODE for illegal detection
//   run       in   gates the fetch request in FETCH
//   mem_ready in   qualifies ir_write in FETCH and the SW retire strobe
//   ctrl      out  packed control vector (not reset-gated here)
module ctrl_out_decode
    import ctrl_pkg::*;
(
    input  state_e     state,
    input  logic [5:0] opcode,
    input  logic       run,
    input  logic       mem_ready,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        unique case (state)
            StFetch: begin
                if (run) begin
                    ctrl.mem_req  = 1'b1;
                    ctrl.ir_write = mem_ready;
                end
            end
            StDecode: begin
                // ALU precomputes the branch target while the opcode is decoded
                ctrl.alu_src_b  = ALUB_IMM;
                ctrl.illegal_op = !is_legal_op(opcode);
            end
            StMemAdr, StAddiEx: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALUB_IMM;
                ctrl.alu_op    = ALU_OP_ADD;
            end
            StMemRd: begin
                ctrl.mem_req = 1'b1;
                ctrl.iord    = 1'b1;
            end
            StMemWb: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.pc_write   = 1'b1;
            end
            StMemWr: begin
                ctrl.mem_req   = 1'b1;
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
                ctrl.pc_write  = mem_ready;
            end
            StExec: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALUB_REG;
                ctrl.alu_op    = ALU_OP_FUNCT;
            end
            StAluWb: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
                ctrl.pc_write  = 1'b1;
            end
            StAddiWb: begin
                ctrl.reg_write = 1'b1;
                ctrl.pc_write  = 1'b1;
            end
            StBranch: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALUB_REG;
                ctrl.alu_op    = ALU_OP_SUB;
                ctrl.branch    = 1'b1;
                ctrl.pc_write  = 1'b1;
            end
            StJump: begin
                ctrl.jump     = 1'b1;
                ctrl.pc_write = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle main control FSM: sequences each instruction through
// fetch/decode/execute/memory/writeback, drives datapath selects, issues one
// pc_write per retired instruction and counts retired instructions.
// Ports:
//   clk, reset (sync, active-low)   run, opcode, mem_ready   (inputs)
//   mem_req, mem_write, iord, ir_write, reg_dst, mem_to_reg, reg_write,
//   alu_src_a, alu_src_b, alu_op, pc_write, branch, jump, illegal_op,
//   instr_count                                              (outputs)
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_write,
    output logic             iord,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             pc_write,
    output logic             branch,
    output logic             jump,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instr_count
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  count_q;
    ctrl_t             ctrl_raw;
    ctrl_t             ctrl_out;

    ctrl_out_decode u_decode (
        .state     (state_q),
        .opcode    (opcode),
        .run       (run),
        .mem_ready (mem_ready),
        .ctrl      (ctrl_raw)
    );

    // Reset forces every strobe low in the same cycle, not just after the edge
    assign ctrl_out = reset ? ctrl_raw : '0;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFetch:  if (run && mem_ready) state_d = StDecode;
            StDecode: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = StMemAdr;
                    OP_RTYPE:     state_d = StExec;
                    OP_BEQ:       state_d = StBranch;
                    OP_J:         state_d = StJump;
                    OP_ADDI:      state_d = StAddiEx;
                    default:      state_d = StFetch;
                endcase
            end
            StMemAdr: state_d = (opcode == OP_SW) ? StMemWr : StMemRd;
            StMemRd:  if (mem_ready) state_d = StMemWb;
            StMemWr:  if (mem_ready) state_d = StFetch;
            StExec:   state_d = StAluWb;
            StAddiEx: state_d = StAddiWb;
            StMemWb, StAluWb, StAddiWb, StBranch, StJump: state_d = StFetch;
            default:  state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StFetch;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            if (ctrl_raw.pc_write) begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

    assign mem_req     = ctrl_out.mem_req;
    assign mem_write   = ctrl_out.mem_write;
    assign iord        = ctrl_out.iord;
    assign ir_write    = ctrl_out.ir_write;
    assign reg_dst     = ctrl_out.reg_dst;
    assign mem_to_reg  = ctrl_out.mem_to_reg;
    assign reg_write   = ctrl_out.reg_write;
    assign alu_src_a   = ctrl_out.alu_src_a;
    assign alu_src_b   = ctrl_out.alu_src_b;
    assign alu_op      = ctrl_out.alu_op;
    assign pc_write    = ctrl_out.pc_write;
    assign branch      = ctrl_out.branch;
    assign jump        = ctrl_out.jump;
    assign illegal_op  = ctrl_out.illegal_op;
    assign instr_count = count_q;

endmodule
